multicast_bus_tx: RTL

Transmitter end of the multicast bus. Accepts tagged words (tag, data, write-type) from the host/global buffer and drives them onto the shared bus consumed by the per-PE `multicast_ctrl` receivers. Handshakes on Enable/Ready, stalls until every receiver on the bus is ready, and inserts a one-cycle tag-settle bubble whenever the destination tag changes.

---
 rtl/mc_bus_pkg.sv | 34 +++
 rtl/mc_tx_fifo.sv | 58 +++++
 rtl/multicast_bus_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mc_bus_pkg.sv
// Shared types and defaults for the multicast bus transmitter and its receivers.
package mc_bus_pkg;

    localparam int MC_DATA_W = 32;
    localparam int MC_TAG_W  = 6;
    localparam logic [MC_TAG_W-1:0] IDLE_TAG = '1;

    typedef enum logic [1:0] {
        WT_WEIGHT = 2'd0,
        WT_IFMAP  = 2'd1,
        WT_PSUM   = 2'd2,
        WT_NONE   = 2'd3
    } wtype_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DRIVE
    } state_e;

    // Write-enable strobes as {psum, ifmap, weight}.
    function automatic logic [2:0] wea_onehot(input logic [1:0] t);
        logic [2:0] w;
        w = 3'b000;
        case (t)
            WT_WEIGHT: w = 3'b001;
            WT_IFMAP:  w = 3'b010;
            WT_PSUM:   w = 3'b100;
            default:   w = 3'b000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mc_tx_fifo.sv
// Synchronous FIFO of packed {type, tag, data} words; exposes head and the entry
// behind it so the bus FSM can decide on back-to-back transfers.
module mc_tx_fifo
    import mc_bus_pkg::*;
#(
    parameter  int W     = 40,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  head_o,
    output logic [W-1:0]  second_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    assign head_o   = mem[rd_q];
    assign second_o = mem[rd_q + 1'b1];
    assign count_o  = cnt_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= wdata_i;
    end

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/multicast_bus_tx.sv
// Multicast bus transmitter: queues host words and drives them onto the shared bus,
// inserting a tag-settle bubble whenever the destination tag changes.
module multicast_bus_tx
    import mc_bus_pkg::*;
#(
    parameter  int DATA_W = MC_DATA_W,
    parameter  int TAG_W  = MC_TAG_W,
    parameter  int NUM_MC = 12,
    parameter  int DEPTH  = 4,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [TAG_W-1:0]  host_tag,
    input  logic [DATA_W-1:0] host_data,
    input  logic [1:0]        host_type,
    output logic [TAG_W-1:0]  Tag_to_Bus,
    output logic [DATA_W-1:0] value_to_Bus,
    output logic              Enable_to_Bus,
    output logic              weight_wea_to_Bus,
    output logic              ifmap_wea_to_Bus,
    output logic              psum_wea_to_Bus,
    input  logic [NUM_MC-1:0] Ready_from_Bus,
    output logic [CW-1:0]     fifo_count,
    output logic              busy
);

    localparam int EW = 2 + TAG_W + DATA_W;
    localparam logic [TAG_W-1:0] IDLE_T = '1;

    state_e            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              en_q, en_d;
    logic [2:0]        wea_q, wea_d;

    logic [EW-1:0]     head, second, incoming, nxt;
    logic [CW-1:0]     count;
    logic              full, empty, push, xfer, bus_ok, nxt_valid;

    logic [1:0]        head_type, nxt_type;
    logic [TAG_W-1:0]  head_tag, nxt_tag;
    logic [DATA_W-1:0] head_data, nxt_data;

    assign host_ready = ~full;
    assign push       = host_valid & host_ready & (host_type != WT_NONE);
    assign bus_ok     = &Ready_from_Bus;
    assign xfer       = en_q & bus_ok;
    assign incoming   = {host_type, host_tag, host_data};

    mc_tx_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .pop_i    (xfer),
        .wdata_i  (incoming),
        .head_o   (head),
        .second_o (second),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    // The word following the head is either already queued or arriving this cycle.
    assign nxt_valid = (count > CW'(1)) | push;
    assign nxt       = (count > CW'(1)) ? second : incoming;

    assign head_type = head[EW-1 -: 2];
    assign head_tag  = head[DATA_W +: TAG_W];
    assign head_data = head[DATA_W-1:0];
    assign nxt_type  = nxt[EW-1 -: 2];
    assign nxt_tag   = nxt[DATA_W +: TAG_W];
    assign nxt_data  = nxt[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        val_d   = val_q;
        en_d    = en_q;
        wea_d   = wea_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_SETTLE;
                    tag_d   = head_tag;
                    val_d   = head_data;
                end
            end
            ST_SETTLE: begin
                state_d = ST_DRIVE;
                en_d    = 1'b1;
                wea_d   = wea_onehot(head_type);
            end
            ST_DRIVE: begin
                if (xfer) begin
                    if (!nxt_valid) begin
                        state_d = ST_IDLE;
                        en_d    = 1'b0;
                        wea_d   = 3'b000;
                        tag_d   = IDLE_T;
                    end else if (nxt_tag == tag_q) begin
                        val_d   = nxt_data;
                        wea_d   = wea_onehot(nxt_type);
                    end else begin
                        state_d = ST_SETTLE;
                        en_d    = 1'b0;
                        wea_d   = 3'b000;
                        tag_d   = nxt_tag;
                        val_d   = nxt_data;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                wea_d   = 3'b000;
                tag_d   = IDLE_T;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tag_q   <= IDLE_T;
            val_q   <= '0;
            en_q    <= 1'b0;
            wea_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
            en_q    <= en_d;
            wea_q   <= wea_d;
        end
    end

    assign Tag_to_Bus        = tag_q;
    assign value_to_Bus      = val_q;
    assign Enable_to_Bus     = en_q;
    assign weight_wea_to_Bus = wea_q[0];
    assign ifmap_wea_to_Bus  = wea_q[1];
    assign psum_wea_to_Bus   = wea_q[2];
    assign fifo_count        = count;
    assign busy              = ~empty | en_q;

endmodule
